// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_arb_pkg: shared types and helpers for the UART TX arbiter -- Rev 1.0
// ---------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int BYTE_W = 8;

    function automatic int rr_next(input int ptr, input int num);
        return (ptr + 1 >= num) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick: rotating-priority selector, first request at or above ptr wins -- Rev 1.0
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] j;

    // Scan from farthest to nearest so the closest request to ptr is written last.
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_arbiter: shares one UART TX byte port among NUM_REQ requesters -- Rev 1.0
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_BURST       = 16,
    parameter int GAP_TIMEOUT     = 64,
    parameter int CTS_SYNC_STAGES = 2
) (
    input  logic                      io_clock,
    input  logic                      io_reset_n,
    input  logic [NUM_REQ-1:0]        io_req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0] io_req_data,
    input  logic [NUM_REQ-1:0]        io_req_last,
    output logic [NUM_REQ-1:0]        io_req_ready,
    output logic                      io_tx_valid,
    output logic [BYTE_W-1:0]         io_tx_data,
    input  logic                      io_tx_ready,
    input  logic                      io_cts_n,
    output logic [NUM_REQ-1:0]        io_grant,
    output logic                      io_busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int GW = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;

    state_t                     state;
    state_t                     state_nxt;
    logic [CTS_SYNC_STAGES-1:0] cts_sync;
    logic                       cts_ok;
    logic [NUM_REQ-1:0]         grant_vec;
    logic [IW-1:0]              grant_idx;
    logic [IW-1:0]              rr_ptr;
    logic [NUM_REQ-1:0]         pick_gnt;
    logic [IW-1:0]              pick_idx;
    logic                       out_full;
    logic [BYTE_W-1:0]          out_data;
    logic [CW-1:0]              byte_cnt;
    logic [GW-1:0]              gap_cnt;
    logic                       valid_g;
    logic                       last_g;
    logic [BYTE_W-1:0]          data_g;
    logic                       accept;
    logic                       gap_end;
    logic                       do_release;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req (io_req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign cts_ok  = ~cts_sync[CTS_SYNC_STAGES-1];
    assign valid_g = io_req_valid[grant_idx];
    assign last_g  = io_req_last[grant_idx];
    assign data_g  = io_req_data[int'(grant_idx)*BYTE_W +: BYTE_W];
    assign accept  = |(io_req_valid & io_req_ready);
    assign gap_end = (GAP_TIMEOUT > 0) && !valid_g && (gap_cnt == GW'(GAP_TIMEOUT - 1));

    // Flops reset to "not clear" so nothing is accepted until CTS has propagated.
    always_ff @(posedge io_clock) begin
        if (!io_reset_n) begin
            cts_sync <= '1;
        end else begin
            cts_sync <= {cts_sync[CTS_SYNC_STAGES-2:0], io_cts_n};
        end
    end

    always_ff @(posedge io_clock) begin
        if (!io_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        do_release = 1'b0;
        case (state)
            IDLE: begin
                if (|io_req_valid) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                do_release = (accept && (last_g || byte_cnt == CW'(MAX_BURST - 1))) || gap_end;
                if (do_release) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        io_req_ready = '0;
        if (state == LOCKED && cts_ok && (!out_full || io_tx_ready)) begin
            io_req_ready = grant_vec;
        end
        io_grant    = grant_vec;
        io_tx_valid = out_full;
        io_tx_data  = out_data;
        io_busy     = (state == LOCKED) || out_full;
    end

    // Release does not wait for the output register; it drains independently.
    always_ff @(posedge io_clock) begin
        if (!io_reset_n) begin
            grant_vec <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            out_full  <= 1'b0;
            out_data  <= '0;
            byte_cnt  <= '0;
            gap_cnt   <= '0;
        end else begin
            if (state == IDLE && |io_req_valid) begin
                grant_vec <= pick_gnt;
                grant_idx <= pick_idx;
            end else if (do_release) begin
                grant_vec <= '0;
                rr_ptr    <= IW'(rr_next(int'(grant_idx), NUM_REQ));
            end

            if (accept) begin
                out_full <= 1'b1;
                out_data <= data_g;
            end else if (io_tx_ready) begin
                out_full <= 1'b0;
            end

            if (do_release) begin
                byte_cnt <= '0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 1'b1;
            end

            if (do_release || state != LOCKED || valid_g) begin
                gap_cnt <= '0;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single board UART transmitter (the io_uartStd_txd path) between NUM_REQ byte-stream requesters, e.g. CPU console, debug logger and status reporter.
- Grants one requester at a time per frame, using round-robin order with burst and gap limits for fairness.
- Honours the UART CTS line before releasing each byte.
- Sits between the requesters and the UART TX byte interface, inside the Nexys4DDR top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before a forced release (1..255).
- GAP_TIMEOUT, 64, idle cycles of the granted requester before release; 0 disables the timeout.
- CTS_SYNC_STAGES, 2, synchronizer depth for io_cts_n (>=2).

Ports:
- io_clock  in  1  system clock.
- io_reset_n  in  1  reset, synchronous, active-low.
- io_req_valid  in  NUM_REQ  per-requester byte valid.
- io_req_data  in  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
- io_req_last  in  NUM_REQ  byte is the last of its frame.
- io_req_ready  out  NUM_REQ  per-requester accept.
- io_tx_valid  out  1  byte to the UART transmitter.
- io_tx_data  out  8  byte value.
- io_tx_ready  in  1  UART transmitter accepts.
- io_cts_n  in  1  asynchronous clear-to-send, active-low.
- io_grant  out  NUM_REQ  one-hot current grant; all zero when idle.
- io_busy  out  1  high while in LOCKED or while the output register is full.

Behaviour:
- Reset (io_reset_n low at an edge):
  - State IDLE; io_tx_valid=0; io_tx_data=0; io_grant=0; io_req_ready=0; io_busy=0.
  - RR pointer=0; byte counter=0; gap timer=0.
  - CTS synchronizer flops=1 (not clear). After reset, cts_ok needs CTS_SYNC_STAGES cycles.
  - Reset mid-frame discards the held byte and the grant. No partial-state survival.
- cts_ok = NOT(synchronized io_cts_n).
- States: IDLE, LOCKED.
- IDLE:
  - If any io_req_valid is high, select the first valid requester searching from the RR pointer upward, with wrap.
  - Register the grant and go to LOCKED next cycle. Arbitration does not depend on cts_ok.
  - io_req_ready=0 in IDLE.
- LOCKED with grant g:
  - io_req_ready[g] = cts_ok AND (out_full=0 OR io_tx_ready). All other ready bits are 0.
  - Accept = io_req_valid[g] AND io_req_ready[g]. On accept, load data[g] into the output register and set out_full at the next edge.
- Output register:
  - io_tx_valid = out_full.
  - Once io_tx_valid is asserted, it and io_tx_data stay stable until io_tx_ready. CTS deassertion never withdraws a held byte; it only blocks new accepts.
  - out_full clears on io_tx_ready unless a simultaneous accept reloads it. Back-to-back gives 1 byte/cycle.
- Latency: valid in IDLE at cycle 0 -> grant at cycle 1 -> accept at cycle 1 (if cts_ok) -> io_tx_valid at cycle 2.
- Byte counter (width clog2(MAX_BURST+1)):
  - Increments on each accept and clears on release.
- Release (LOCKED->IDLE at the next edge, grant cleared, RR pointer=(g+1) mod NUM_REQ) on any of:
  - accept with io_req_last[g]=1;
  - accept when counter==MAX_BURST-1;
  - gap timer==GAP_TIMEOUT-1 with io_req_valid[g]=0 (only when GAP_TIMEOUT>0).
- Gap timer:
  - Increments each LOCKED cycle with io_req_valid[g]=0.
  - Clears on io_req_valid[g]=1 and on release.
  - It does not count while valid is high but blocked by CTS.
- Release does not wait for the output register to drain. The next grant can accept once the register is free.
- Simultaneous last and MAX_BURST on the same accept produce a single release.

Decomposition:
- Package uart_arb_pkg:
  - state enum {IDLE, LOCKED};
  - BYTE_W=8 constant;
  - function for the RR pointer increment with wrap.
- Sub-module rr_pick: combinational rotating-priority selector. Inputs: request vector and pointer. Outputs: one-hot grant and index. Instantiated once.
- The CTS synchronizer is inline flops.

Test Plan:
- Single requester, 3-byte frame 0x41,0x42,0x43 with last on 0x43, cts_n=0, tx_ready=1 -> tx bytes on cycles 2,3,4; grant returns to 0 after the last byte; RR pointer=1.
- Requesters 0 and 2 both valid, 1-byte frames -> order is req0 then req2; next round with both valid again, req2 is served first only if the pointer is past 0. Check grant one-hot and the pointer sequence 1, 3.
- Requester 1 streams 20 bytes with no last, MAX_BURST=16, requester 3 pending -> release after the 16th accept; requester 3 granted next; requester 1 resumes afterwards.
- cts_n raised while a byte is held and tx_ready=0 -> io_tx_valid/data remain stable. No new accept after 2 sync cycles. Lowering cts_n resumes after 2 cycles.
- Granted requester drops valid for 64 cycles, GAP_TIMEOUT=64 -> release on cycle 64; a 63-cycle gap followed by valid keeps the grant.
- io_reset_n pulsed low mid-frame with out_full=1 -> next edge io_tx_valid=0, io_grant=0, io_busy=0; the held byte is never emitted.
